// File: rtl/rtc_capture_bank.sv
// Multiplexed address/data capture into a shadow register bank, committed atomically to a display bank on frame_sync.
// Optional feature: define BCD_CHECK_EN to reject data bytes that are not valid packed BCD (DATA_W == 8 only).
module rtc_capture_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_vld,
  input  logic              a_d,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              frame_sync,
  input  logic [ADDR_W-1:0] rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] dirty,
  output logic              commit,
  output logic              proto_err
);

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_HAVE_ADDR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shadow_q  [NUM_CH];
  logic [DATA_W-1:0] shadow_d  [NUM_CH];
  logic [DATA_W-1:0] display_q [NUM_CH];
  logic [DATA_W-1:0] display_d [NUM_CH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_CH-1:0] dirty_q, dirty_d;
  logic              commit_q, commit_d;
  logic              proto_err_q, proto_err_d;
  logic              addr_ok_c;
  logic              bcd_bad_c;

  assign addr_ok_c = (32'(addr_q) < NUM_CH);

  // A byte with either nibble above 9 is not a packed BCD value.
`ifdef BCD_CHECK_EN
  if (DATA_W == 8) begin : g_bcd
    assign bcd_bad_c = (bus_data[7:4] > 4'd9) || (bus_data[3:0] > 4'd9);
  end else begin : g_no_bcd
    assign bcd_bad_c = 1'b0;
  end
`else
  assign bcd_bad_c = 1'b0;
`endif

  // Next-state, bank update and read mux.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    display_d   = display_q;
    dirty_d     = dirty_q;
    proto_err_d = proto_err_q;
    commit_d    = frame_sync;
    rd_data_d   = '0;

    // Commit copies the pre-write shadow; a same-cycle write re-marks its dirty bit below.
    if (frame_sync) begin
      display_d = shadow_q;
      dirty_d   = '0;
    end

    if (bus_vld) begin
      case (state_q)
        S_IDLE: begin
          if (!a_d) begin
            addr_d  = bus_data[ADDR_W-1:0];
            state_d = S_HAVE_ADDR;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        S_HAVE_ADDR: begin
          if (!a_d) begin
            addr_d = bus_data[ADDR_W-1:0];
          end else begin
            state_d = S_IDLE;
            if (!addr_ok_c || bcd_bad_c) begin
              proto_err_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (32'(addr_q) == i) begin
                  shadow_d[i] = bus_data;
                  dirty_d[i]  = 1'b1;
                end
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Out-of-range channels read as zero.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(rd_ch) == i) begin
        rd_data_d = display_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      shadow_q    <= '{default: '0};
      display_q   <= '{default: '0};
      rd_data_q   <= '0;
      dirty_q     <= '0;
      commit_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      shadow_q    <= shadow_d;
      display_q   <= display_d;
      rd_data_q   <= rd_data_d;
      dirty_q     <= dirty_d;
      commit_q    <= commit_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign dirty     = dirty_q;
  assign commit    = commit_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_rtc_capture_bank.sv
// Directed vector bench for rtc_capture_bank (NUM_CH=9); expectations follow BCD_CHECK_EN when defined.
module tb_rtc_capture_bank;

  logic       clk;
  logic       reset;
  logic       bus_vld;
  logic       a_d;
  logic [7:0] bus_data;
  logic       frame_sync;
  logic [3:0] rd_ch;
  logic [7:0] rd_data;
  logic [8:0] dirty;
  logic       commit;
  logic       proto_err;

  int n_vec;
  int n_bad;

`ifdef BCD_CHECK_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       vld;
    logic       ad;
    logic [7:0] data;
    logic       fs;
    logic [3:0] ch;
    logic [7:0] e_rd;
    logic [8:0] e_dirty;
    logic       e_commit;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  rtc_capture_bank #(.DATA_W(8), .NUM_CH(9), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_vld    (bus_vld),
    .a_d        (a_d),
    .bus_data   (bus_data),
    .frame_sync (frame_sync),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .dirty      (dirty),
    .commit     (commit),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic vld, logic ad, logic [7:0] data, logic fs,
                              logic [3:0] ch, logic [7:0] e_rd, logic [8:0] e_dirty,
                              logic e_commit, logic e_err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ad = ad; v.data = data; v.fs = fs; v.ch = ch;
    v.e_rd = e_rd; v.e_dirty = e_dirty; v.e_commit = e_commit; v.e_err = e_err;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge, then step past the rising edge.
  task automatic cyc(input logic rst, input logic vld, input logic ad, input logic [7:0] data,
                     input logic fs, input logic [3:0] ch);
    @(negedge clk);
    reset = rst; bus_vld = vld; a_d = ad; bus_data = data; frame_sync = fs; rd_ch = ch;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    bit bad;
    bit seen;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1; bus_vld = 1'b0; a_d = 1'b0; bus_data = 8'h00; frame_sync = 1'b0; rd_ch = 4'd0;

    //                rst  vld  ad   data   fs   ch     e_rd   e_dirty  cm   err
    vecs.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b0)); // 0 reset
    vecs.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b0,4'd5, 8'h00, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd8, 8'h00, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd15,8'h00, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h02,1'b0,4'd2, 8'h00, 9'h000, 1'b0,1'b0)); // 4 addr 2
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h45,1'b0,4'd2, 8'h00, 9'h004, 1'b0,1'b0)); // data 45
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b1,4'd2, 8'h00, 9'h000, 1'b1,1'b0)); // sync
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd2, 8'h45, 9'h000, 1'b0,1'b0)); // N+2
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b0)); // 8 addr 0
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h59,1'b1,4'd0, 8'h00, 9'h001, 1'b1,1'b0)); // write+sync
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd0, 8'h00, 9'h001, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b1,4'd0, 8'h00, 9'h000, 1'b1,1'b0)); // sync
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd0, 8'h59, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd2, 8'h45, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h03,1'b0,4'd2, 8'h45, 9'h000, 1'b0,1'b0)); // 14 addr 3
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h05,1'b0,4'd2, 8'h45, 9'h000, 1'b0,1'b0)); // addr 5
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h12,1'b0,4'd2, 8'h45, 9'h020, 1'b0,1'b0)); // data 12
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b1,4'd3, 8'h00, 9'h000, 1'b1,1'b0)); // sync
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd5, 8'h12, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd3, 8'h00, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h01,1'b0,4'd5, 8'h12, 9'h000, 1'b0,1'b0)); // 20 addr 1
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h3A,1'b0,4'd5, 8'h12, BCD ? 9'h000 : 9'h002, 1'b0, BCD));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b1,4'd1, 8'h00, 9'h000, 1'b1, BCD));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd1, BCD ? 8'h00 : 8'h3A, 9'h000, 1'b0, BCD));
    vecs.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b0,4'd1, 8'h00, 9'h000, 1'b0,1'b0)); // 24 reset
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd1, 8'h00, 9'h000, 1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h77,1'b0,4'd1, 8'h00, 9'h000, 1'b0,1'b1)); // data in IDLE
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h0F,1'b0,4'd1, 8'h00, 9'h000, 1'b0,1'b1)); // addr 15
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h33,1'b0,4'd1, 8'h00, 9'h000, 1'b0,1'b1)); // range err
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b1,4'd0, 8'h00, 9'h000, 1'b1,1'b1)); // sync
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd15,8'h00, 9'h000, 1'b0,1'b1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b0)); // 32 reset
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h02,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b0)); // addr 2
    vecs.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b0)); // reset mid-txn
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h11,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b1)); // orphan data
    vecs.push_back(mk(1'b0,1'b1,1'b0,8'h08,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b1)); // addr 8
    vecs.push_back(mk(1'b0,1'b0,1'b1,8'h55,1'b0,4'd0, 8'h00, 9'h000, 1'b0,1'b1)); // idle bus
    vecs.push_back(mk(1'b0,1'b1,1'b1,8'h99,1'b0,4'd0, 8'h00, 9'h100, 1'b0,1'b1)); // data 99
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b1,4'd8, 8'h00, 9'h000, 1'b1,1'b1)); // sync
    vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,4'd8, 8'h99, 9'h000, 1'b0,1'b1));

    foreach (vecs[k]) begin
      cyc(vecs[k].rst, vecs[k].vld, vecs[k].ad, vecs[k].data, vecs[k].fs, vecs[k].ch);
      n_vec++;
      bad = 1'b0;
      if (rd_data !== vecs[k].e_rd) begin
        bad = 1'b1;
        $display("FAIL vec%0d rd_data: got 0x%0h, expected 0x%0h", k, rd_data, vecs[k].e_rd);
      end
      if (dirty !== vecs[k].e_dirty) begin
        bad = 1'b1;
        $display("FAIL vec%0d dirty: got 0x%0h, expected 0x%0h", k, dirty, vecs[k].e_dirty);
      end
      if (commit !== vecs[k].e_commit) begin
        bad = 1'b1;
        $display("FAIL vec%0d commit: got %0b, expected %0b", k, commit, vecs[k].e_commit);
      end
      if (proto_err !== vecs[k].e_err) begin
        bad = 1'b1;
        $display("FAIL vec%0d proto_err: got %0b, expected %0b", k, proto_err, vecs[k].e_err);
      end
      if (bad) n_bad++;
    end

    // Commit latency: wait (bounded) for the commit pulse, then expect the new value one cycle later.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd4);
    cyc(1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 4'd4);
    cyc(1'b0, 1'b1, 1'b1, 8'h23, 1'b0, 4'd4);
    chk("lat_dirty_before_sync", 32'(dirty), 32'h010);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd4);
    seen = commit;
    for (int c = 0; c < 4 && !seen; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd4);
      seen = commit;
    end
    chk("lat_commit_seen", 32'(seen), 32'd1);
    chk("lat_rd_old_at_commit", 32'(rd_data), 32'h00);
    chk("lat_dirty_cleared", 32'(dirty), 32'h000);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd4);
    chk("lat_rd_new", 32'(rd_data), 32'h23);
    chk("lat_commit_single", 32'(commit), 32'd0);

    // Back-to-back syncs with nothing dirty still pulse commit each time.
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd4);
    chk("empty_commit_1", 32'(commit), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd4);
    chk("empty_commit_2", 32'(commit), 32'd1);
    chk("empty_commit_rd", 32'(rd_data), 32'h23);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
